uart_rx_mmio: RTL and testbench
===============================

# uart_rx_mmio

UART receiver peripheral for the SoC IO block: the receive-side counterpart of the existing UART TX register. It oversamples the asynchronous `uart_rx` pin, decodes 8N1 frames (LSB first), and buffers received bytes in a small FIFO. Harts read the bytes and the status through a single-cycle MMIO register port. The IO block performs base-address decode and presents only the register offset.

## Interface

- `CLKS_PER_BIT`, default 868: clock cycles per bit (100 MHz / 115200 baud); minimum 8.
- `FIFO_DEPTH`, default 4: receive FIFO entries; must be a power of two.
- `clk` in 1: clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `uart_rx` in 1: asynchronous serial input; idles high.
- `req` in 1: MMIO access strobe, valid for one cycle.
- `we` in 1: 1 = write, 0 = read.
- `addr` in 4: byte offset. 0x0 = RXDATA, 0x4 = STATUS.
- `wdata` in 32: write data.
- `rdata` out 32: read data; combinational, valid when `req && !we`.
- `ready` out 1: equals `req`; every access completes in one cycle.
- `rx_irq` out 1: 1 while the FIFO is non-empty; registered.

## Operation

**Input synchronizer**
- Two flops, both reset to 1.
- All decode logic uses the second flop output `rx_s`.

**Receive FSM** (states IDLE, START, DATA, STOP, WAIT_HIGH). `cnt` is the bit-period counter; `bitn` counts data bits 0..7.
- IDLE: if `rx_s == 0`, go to START and clear `cnt`.
- START: when `cnt == CLKS_PER_BIT/2 - 1`:
  - `rx_s == 0`: go to DATA with `cnt = 0` and `bitn = 0`.
  - `rx_s == 1`: treat as a glitch and return to IDLE.
- DATA: when `cnt == CLKS_PER_BIT - 1`:
  - shift `rx_s` into `shreg[7]`, shifting right, so the first received bit ends in bit 0;
  - increment `bitn`, reset `cnt`;
  - after the 8th bit, go to STOP.
- STOP: when `cnt == CLKS_PER_BIT - 1`, sample `rx_s`:
  - 1 and FIFO not full (or popped the same cycle): push `shreg` and go to IDLE.
  - 1 and FIFO full with no pop that cycle: set `overrun`, drop the byte, go to IDLE.
  - 0: set `frame_err`, drop the byte, go to WAIT_HIGH.
- WAIT_HIGH: stay until `rx_s == 1`, then go to IDLE. A break condition therefore never produces repeated frames.

**FIFO**
- Circular buffer with `wr_ptr`, `rd_ptr`, and `count`; `count` width is log2(FIFO_DEPTH)+1.
- Pointers wrap modulo FIFO_DEPTH.
- Simultaneous push and pop: both take effect and `count` is unchanged. This includes the full case, which does not set `overrun`.

**Registers**
- RXDATA read:
  - `rdata = {24'b0, fifo[rd_ptr]}` when non-empty, else 0.
  - A read while non-empty pops one entry at the clock edge.
  - A read while empty pops nothing.
- STATUS read: `rdata[0]` = non-empty, `[1]` = full, `[2]` = frame_err, `[3]` = overrun, `[10:8]` = count, all other bits 0. Reads have no side effects.
- STATUS write: write-1-to-clear for `wdata[2]` (frame_err) and `wdata[3]` (overrun).
  - If a clear and a new error event land in the same cycle, set wins.
- Writes to RXDATA, and any access to another offset, are ignored; reads of other offsets return 0.

## Timing

- Reset values:
  - FSM = IDLE, FIFO empty (pointers and count 0), `frame_err = overrun = 0`;
  - `rx_irq = 0`, synchronizer flops = 1, `shreg = 0`.
- Reset mid-frame aborts the frame and discards the partial byte. The next falling edge after reset release is decoded normally.
- Start detect: 2 cycles of synchronizer latency after the pin falls.
- The pushed byte is visible in RXDATA/STATUS, and `rx_irq` rises, in the cycle after the clock edge at which the stop bit is sampled.
- About 9.5 bit periods pass from the start-bit falling edge to the push.
- MMIO: `ready` is asserted in the `req` cycle. The pop, and any W1C clear, takes effect at that cycle's rising edge. A STATUS read in the following cycle reflects the result.
- Back-to-back frames: the FSM returns to IDLE at the stop-bit midpoint, so the next start bit may begin immediately after the nominal stop bit ends.

## Test plan

Run with `CLKS_PER_BIT = 16` and `FIFO_DEPTH = 4`.

- **Single byte:** drive frame 0x55 on `uart_rx` → `rx_irq = 1`, STATUS = 0x101; RXDATA read returns 0x55; next STATUS = 0x000 and `rx_irq = 0`.
- **Back-to-back and overrun:** drive frames 0x00, 0x11, 0x22, 0x33, 0x44 with no reads → STATUS = 0x40B (count 4, full, overrun). Four RXDATA reads return 0x00, 0x11, 0x22, 0x33. Write STATUS 0x8 → overrun clears.
- **Framing error and break:** drive 0xA5 with stop bit 0, then hold the line low for 40 bit times → STATUS = 0x004 and the FIFO stays empty. Release the line, then send 0x3C → RXDATA = 0x3C.
- **Glitch rejection:** drive a 4-cycle low pulse → no START-to-DATA transition, FIFO stays empty, no error flags set.
- **Push/pop collision:** with the FIFO full, issue an RXDATA read in the exact cycle the stop bit of 0x77 is sampled → the read returns the oldest byte, count stays 4, overrun = 0, and 0x77 is the last entry read out.
- **Reset mid-frame:** assert `rst_n = 0` for 2 cycles during data bit 3 of a frame → all state resets. A subsequent frame 0xC3 is received correctly and count = 1.

Source files
------------

// File: rtl/uart_rx_mmio.sv
// UART receiver peripheral: oversampled 8N1 decode into a small byte FIFO,
// read by harts through a single-cycle MMIO port (RXDATA at 0x0, STATUS at 0x4).
module uart_rx_mmio #(
   parameter int CLKS_PER_BIT = 868,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        uart_rx,
   input  logic        req,
   input  logic        we,
   input  logic [3:0]  addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        ready,
   output logic        rx_irq
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [AW:0]   DEPTH     = (AW + 1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_HIGH
   } rxState_e;

   rxState_e        state_q;
   logic            rxSync1_q;
   logic            rxSync2_q;
   logic [CW-1:0]   cnt_q;
   logic [2:0]      bitN_q;
   logic [7:0]      shReg_q;

   logic [7:0]      mem_q [FIFO_DEPTH];
   logic [AW-1:0]   wrPtr_q;
   logic [AW-1:0]   rdPtr_q;
   logic [AW:0]     count_q;
   logic [AW:0]     count_d;
   logic            frameErr_q;
   logic            overrun_q;
   logic            rxIrq_q;

   logic            isEmpty;
   logic            isFull;
   logic            selData;
   logic            selStatus;
   logic            pop;
   logic            push;
   logic            stopSample;
   logic            overrunSet;
   logic            frameErrSet;
   logic            overrunClr;
   logic            frameErrClr;
   logic            unusedBits;

   assign isEmpty     = (count_q == '0);
   assign isFull      = (count_q == DEPTH);
   assign selData     = (addr == 4'h0);
   assign selStatus   = (addr == 4'h4);
   assign pop         = req && !we && selData && !isEmpty;
   assign stopSample  = (state_q == STOP) && (cnt_q == BIT_LAST);
   assign push        = stopSample && rxSync2_q && (!isFull || pop);
   assign overrunSet  = stopSample && rxSync2_q && isFull && !pop;
   assign frameErrSet = stopSample && !rxSync2_q;
   assign frameErrClr = req && we && selStatus && wdata[2];
   assign overrunClr  = req && we && selStatus && wdata[3];
   assign unusedBits  = ^{wdata[31:4], wdata[1:0]};

   assign ready  = req;
   assign rx_irq = rxIrq_q;

   // Two-flop synchronizer; resets high so reset release never looks like a start bit.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rxSync1_q <= 1'b1;
         rxSync2_q <= 1'b1;
      end else begin
         rxSync1_q <= uart_rx;
         rxSync2_q <= rxSync1_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bitN_q  <= '0;
         shReg_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (!rxSync2_q) begin
                  state_q <= START;
                  cnt_q   <= '0;
               end
            end
            START: begin
               // Re-check the line at mid start bit to reject short glitches.
               if (cnt_q == HALF_LAST) begin
                  cnt_q <= '0;
                  if (!rxSync2_q) begin
                     state_q <= DATA;
                     bitN_q  <= '0;
                  end else begin
                     state_q <= IDLE;
                  end
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            DATA: begin
               if (cnt_q == BIT_LAST) begin
                  shReg_q <= {rxSync2_q, shReg_q[7:1]};
                  bitN_q  <= bitN_q + 3'd1;
                  cnt_q   <= '0;
                  if (bitN_q == 3'd7) begin
                     state_q <= STOP;
                  end
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            STOP: begin
               if (cnt_q == BIT_LAST) begin
                  cnt_q   <= '0;
                  state_q <= rxSync2_q ? IDLE : WAIT_HIGH;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            WAIT_HIGH: begin
               if (rxSync2_q) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   always_comb begin
      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + (AW + 1)'(1);
      end else if (pop && !push) begin
         count_d = count_q - (AW + 1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wrPtr_q] <= shReg_q;
      end
   end

   // Pointers wrap naturally at FIFO_DEPTH; the irq tracks the post-edge fill level.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
         rxIrq_q <= 1'b0;
      end else begin
         if (push) begin
            wrPtr_q <= wrPtr_q + AW'(1);
         end
         if (pop) begin
            rdPtr_q <= rdPtr_q + AW'(1);
         end
         count_q <= count_d;
         rxIrq_q <= (count_d != '0);
      end
   end

   // Sticky error flags; a new event outranks a simultaneous clear.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         frameErr_q <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         frameErr_q <= frameErrSet | (frameErr_q & ~frameErrClr);
         overrun_q  <= overrunSet | (overrun_q & ~overrunClr);
      end
   end

   always_comb begin
      rdata = '0;
      if (req && !we) begin
         if (selData && !isEmpty) begin
            rdata = {24'b0, mem_q[rdPtr_q]};
         end else if (selStatus) begin
            rdata[0]          = !isEmpty;
            rdata[1]          = isFull;
            rdata[2]          = frameErr_q;
            rdata[3]          = overrun_q;
            rdata[8 +: AW+1]  = count_q;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_mmio.sv
// Directed self-checking bench for uart_rx_mmio with 16 clocks per bit and a 4-deep FIFO.
// All tasks start and end on a falling clock edge.
module tb_uart_rx_mmio;

   localparam int CLKS = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        uart_rx = 1'b1;
   logic        req = 1'b0;
   logic        we = 1'b0;
   logic [3:0]  addr = 4'h0;
   logic [31:0] wdata = 32'h0;
   logic [31:0] rdata;
   logic        ready;
   logic        rx_irq;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] rd;
   logic        lastReady;

   always #5 clk = ~clk;

   uart_rx_mmio #(
      .CLKS_PER_BIT(CLKS),
      .FIFO_DEPTH(4)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .uart_rx(uart_rx),
      .req(req),
      .we(we),
      .addr(addr),
      .wdata(wdata),
      .rdata(rdata),
      .ready(ready),
      .rx_irq(rx_irq)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Drives one 8N1 frame (LSB first) with a selectable stop-bit level.
   task automatic applyStimulus(input logic [7:0] data, input logic stopBit);
      uart_rx = 1'b0;
      idle(CLKS);
      for (int i = 0; i < 8; i++) begin
         uart_rx = data[i];
         idle(CLKS);
      end
      uart_rx = stopBit;
      idle(CLKS);
   endtask

   task automatic mmioRead(input logic [3:0] a, output logic [31:0] d);
      req  = 1'b1;
      we   = 1'b0;
      addr = a;
      #1;
      d = rdata;
      lastReady = ready;
      @(negedge clk);
      req = 1'b0;
   endtask

   task automatic mmioWrite(input logic [3:0] a, input logic [31:0] wd);
      req   = 1'b1;
      we    = 1'b1;
      addr  = a;
      wdata = wd;
      @(negedge clk);
      req   = 1'b0;
      we    = 1'b0;
      wdata = 32'h0;
   endtask

   initial begin
      logic [7:0] fill [4];
      fill[0] = 8'h10; fill[1] = 8'h20; fill[2] = 8'h30; fill[3] = 8'h40;

      idle(3);
      checkOutput("reset_irq", {31'b0, rx_irq}, 32'h0);
      rst_n = 1'b1;
      idle(1);
      checkOutput("reset_ready_idle", {31'b0, ready}, 32'h0);
      mmioRead(4'h4, rd); checkOutput("reset_status", rd, 32'h0);
      mmioRead(4'h0, rd); checkOutput("empty_rxdata", rd, 32'h0);

      $display("[TB] single byte");
      applyStimulus(8'h55, 1'b1);
      idle(2);
      checkOutput("single_irq", {31'b0, rx_irq}, 32'h1);
      mmioRead(4'h4, rd); checkOutput("single_status", rd, 32'h101);
      checkOutput("ready_on_req", {31'b0, lastReady}, 32'h1);
      mmioWrite(4'h0, 32'hFF);
      mmioRead(4'h8, rd); checkOutput("other_offset", rd, 32'h0);
      mmioRead(4'h4, rd); checkOutput("status_after_ignored", rd, 32'h101);
      mmioRead(4'h0, rd); checkOutput("single_data", rd, 32'h55);
      mmioRead(4'h4, rd); checkOutput("single_status_empty", rd, 32'h0);
      checkOutput("single_irq_low", {31'b0, rx_irq}, 32'h0);

      $display("[TB] back-to-back and overrun");
      for (int i = 0; i < 5; i++) begin
         applyStimulus(8'(i * 8'h11), 1'b1);
      end
      idle(2);
      mmioRead(4'h4, rd); checkOutput("overrun_status", rd, 32'h40B);
      for (int i = 0; i < 4; i++) begin
         mmioRead(4'h0, rd); checkOutput("b2b_data", rd, 32'(i * 8'h11));
      end
      mmioRead(4'h4, rd); checkOutput("overrun_sticky", rd, 32'h8);
      mmioWrite(4'h4, 32'h8);
      mmioRead(4'h4, rd); checkOutput("overrun_cleared", rd, 32'h0);

      $display("[TB] framing error and break");
      applyStimulus(8'hA5, 1'b0);
      idle(40 * CLKS);
      mmioRead(4'h4, rd); checkOutput("frame_err_status", rd, 32'h4);
      uart_rx = 1'b1;
      idle(2 * CLKS);
      applyStimulus(8'h3C, 1'b1);
      idle(2);
      mmioRead(4'h4, rd); checkOutput("after_break_status", rd, 32'h105);
      mmioRead(4'h0, rd); checkOutput("after_break_data", rd, 32'h3C);
      mmioWrite(4'h4, 32'h4);
      mmioRead(4'h4, rd); checkOutput("frame_err_cleared", rd, 32'h0);

      $display("[TB] glitch rejection");
      uart_rx = 1'b0;
      idle(4);
      uart_rx = 1'b1;
      idle(2 * CLKS);
      mmioRead(4'h4, rd); checkOutput("glitch_status", rd, 32'h0);
      applyStimulus(8'h96, 1'b1);
      idle(2);
      mmioRead(4'h0, rd); checkOutput("post_glitch_data", rd, 32'h96);

      $display("[TB] push/pop collision");
      for (int i = 0; i < 4; i++) begin
         applyStimulus(fill[i], 1'b1);
      end
      idle(2);
      mmioRead(4'h4, rd); checkOutput("full_status", rd, 32'h403);
      fork
         applyStimulus(8'h77, 1'b1);
         begin
            idle(9 * CLKS + 10);
            mmioRead(4'h0, rd);
            checkOutput("collision_data", rd, 32'h10);
         end
      join
      idle(2);
      mmioRead(4'h4, rd); checkOutput("collision_status", rd, 32'h403);
      for (int i = 1; i < 4; i++) begin
         mmioRead(4'h0, rd); checkOutput("collision_drain", rd, {24'b0, fill[i]});
      end
      mmioRead(4'h0, rd); checkOutput("collision_last", rd, 32'h77);
      mmioRead(4'h4, rd); checkOutput("collision_empty", rd, 32'h0);

      $display("[TB] reset mid-frame");
      applyStimulus(8'h5A, 1'b1);
      idle(2);
      mmioRead(4'h4, rd); checkOutput("pre_reset_status", rd, 32'h101);
      uart_rx = 1'b0;
      idle(CLKS);
      uart_rx = 1'b0; idle(CLKS);
      uart_rx = 1'b1; idle(CLKS);
      uart_rx = 1'b0; idle(CLKS);
      uart_rx = 1'b1; idle(8);
      rst_n = 1'b0;
      idle(2);
      rst_n = 1'b1;
      uart_rx = 1'b1;
      idle(CLKS);
      checkOutput("post_reset_irq", {31'b0, rx_irq}, 32'h0);
      mmioRead(4'h4, rd); checkOutput("post_reset_status", rd, 32'h0);
      applyStimulus(8'hC3, 1'b1);
      idle(2);
      mmioRead(4'h4, rd); checkOutput("post_reset_count", rd, 32'h101);
      mmioRead(4'h0, rd); checkOutput("post_reset_data", rd, 32'hC3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
